// File: rtl/mmul_feeder.sv
// Byte-serial loader for the 2x2 Q8.8 multiplier.
// Two-bank frame buffer, presented as integer then fractional operand bytes.
module mmul_feeder #(
  parameter bit ACK_EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic [7:0] a11,
  output logic [7:0] a12,
  output logic [7:0] a21,
  output logic [7:0] a22,
  output logic [7:0] b11,
  output logic [7:0] b12,
  output logic [7:0] b21,
  output logic [7:0] b22,
  output logic       in_rdy1,
  output logic       in_rdy2,
  input  logic       read_in1,
  input  logic       read_in2,
  output logic [1:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    INT,
    DEC
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] mem [2][16];
  logic [1:0] full_q;
  logic       wp_q, rp_q;
  logic [3:0] wi_q;
  logic       r1_q, r2_q;
  logic       ack1, ack2;
  logic       acc, rel;
  logic [7:0] ops_q [8];
  logic [7:0] ops_d [8];
  logic       rdy1_d, rdy2_d;

  assign s_ready = ~full_q[wp_q];
  assign acc     = s_valid & s_ready;
  assign pending = {1'b0, full_q[0]} + {1'b0, full_q[1]};

  // A level held high across state entry is not an acknowledge in edge mode.
  assign ack1 = ACK_EDGE ? (read_in1 & ~r1_q) : read_in1;
  assign ack2 = ACK_EDGE ? (read_in2 & ~r2_q) : read_in2;

  always_ff @(posedge clk) begin
    if (acc) begin
      mem[wp_q][wi_q] <= s_data;
    end
  end

  // A load only targets an empty bank and a release only a full one,
  // so both updates to full_q never hit the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= '0;
      wp_q   <= 1'b0;
      rp_q   <= 1'b0;
      wi_q   <= '0;
      r1_q   <= 1'b0;
      r2_q   <= 1'b0;
    end else begin
      r1_q <= read_in1;
      r2_q <= read_in2;
      if (acc) begin
        wi_q <= wi_q + 4'd1;
        if (wi_q == 4'hf) begin
          full_q[wp_q] <= 1'b1;
          wp_q         <= ~wp_q;
        end
      end
      if (rel) begin
        full_q[rp_q] <= 1'b0;
        rp_q         <= ~rp_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rdy1_d  = in_rdy1;
    rdy2_d  = in_rdy2;
    ops_d   = ops_q;
    rel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rp_q]) begin
          for (int i = 0; i < 8; i++) begin
            ops_d[i] = mem[rp_q][{i[2:0], 1'b0}];
          end
          rdy1_d  = 1'b1;
          state_d = INT;
        end
      end
      INT: begin
        if (ack1) begin
          for (int i = 0; i < 8; i++) begin
            ops_d[i] = mem[rp_q][{i[2:0], 1'b1}];
          end
          rdy1_d  = 1'b0;
          rdy2_d  = 1'b1;
          state_d = DEC;
        end
      end
      DEC: begin
        if (ack2) begin
          for (int i = 0; i < 8; i++) begin
            ops_d[i] = '0;
          end
          rdy2_d  = 1'b0;
          rel     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      in_rdy1 <= 1'b0;
      in_rdy2 <= 1'b0;
      ops_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      in_rdy1 <= rdy1_d;
      in_rdy2 <= rdy2_d;
      ops_q   <= ops_d;
    end
  end

  assign a11 = ops_q[0];
  assign a12 = ops_q[1];
  assign a21 = ops_q[2];
  assign a22 = ops_q[3];
  assign b11 = ops_q[4];
  assign b12 = ops_q[5];
  assign b21 = ops_q[6];
  assign b22 = ops_q[7];

endmodule
